// File: rtl/machdich_input_ctrl.sv
// -----------------------------------------------------------------------------
// machdich_input_ctrl
//   Front-end control stage for the machdich LED pattern engine.
//   Synchronises and debounces the RUN and MODE push-buttons, and drives the
//   engine's ss (run/hold) and mode inputs. It also produces the step_tick pacing
//   pulse and a mode_chg pulse.
//
//   Optional feature: define MACHDICH_AUTO_MODE_EN to enable auto mode cycling.
//   In that build the mode advances automatically after every AUTO_STEPS ticks.
// -----------------------------------------------------------------------------
module machdich_input_ctrl #(
   parameter int DEB_CYCLES = 500000,   // stable cycles before a level is accepted
   parameter int TICK_DIV   = 12500000, // clk cycles per step_tick while running
   parameter int AUTO_STEPS = 32        // ticks per mode in auto-cycle build
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_run,
   input  logic       btn_mode,
   output logic       ss,
   output logic [1:0] mode,
   output logic       step_tick,
   output logic       mode_chg
);

   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   // Elaboration-time parameter sanity checks.
   if (TICK_DIV < 2 || DEB_CYCLES < 1 || AUTO_STEPS < 1) begin : g_bad_params
      $error("machdich_input_ctrl: TICK_DIV must be >= 2, DEB_CYCLES and AUTO_STEPS >= 1");
   end

   // Bit 0 = RUN button, bit 1 = MODE button.
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    deb_q;
   logic [1:0]    deb_prev;
   logic [DW-1:0] deb_cnt [2];
   logic [1:0]    press;
   logic          run_ev;
   logic          mode_ev;
   logic          auto_ev;
   logic          adv;
   logic [PW-1:0] presc;

   // Two-flop synchroniser and per-button debounce counter.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1    <= '0;
         sync2    <= '0;
         deb_q    <= '0;
         deb_prev <= '0;
         // NOTE: deb_cnt is a two-entry register array, not a RAM, so it is
         // cheap and safe to clear it on reset like any other flop.
         for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
      end else begin
         sync1    <= {btn_mode, btn_run};
         sync2    <= sync1;
         deb_prev <= deb_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == deb_q[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb_q[i]   <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DW'(1);
            end
         end
      end
   end

   // Press events are the rising edge of the debounced level; release is ignored.
   assign press   = deb_q & ~deb_prev;
   assign run_ev  = press[0];
   assign mode_ev = press[1];

`ifdef MACHDICH_AUTO_MODE_EN
   localparam int AW = (AUTO_STEPS > 1) ? $clog2(AUTO_STEPS) : 1;
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_STEPS - 1);

   logic [AW-1:0] auto_cnt;

   // The last tick of a group advances the mode in the following cycle.
   assign auto_ev = step_tick && (auto_cnt == AUTO_LAST);

   // Counts issued ticks; it only moves on a tick, so hold freezes it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         auto_cnt <= '0;
      end else if (mode_ev || auto_ev) begin
         auto_cnt <= '0;
      end else if (step_tick) begin
         auto_cnt <= auto_cnt + AW'(1);
      end
   end
`else
   assign auto_ev = 1'b0;
`endif

   // Manual and auto advance in the same cycle still step the mode only once.
   assign adv = mode_ev | auto_ev;

   // Run/hold, mode select and step prescaler; every output is a flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ss        <= 1'b1;
         mode      <= 2'b00;
         mode_chg  <= 1'b0;
         step_tick <= 1'b0;
         presc     <= '0;
      end else begin
         if (run_ev) ss <= ~ss;
         if (adv) mode <= mode + 2'd1;
         mode_chg <= adv;
         // A hold or a mode change restarts a full tick period.
         if (ss || adv) begin
            presc     <= '0;
            step_tick <= 1'b0;
         end else if (presc == TICK_LAST) begin
            presc     <= '0;
            // No tick in the cycle that enters hold.
            step_tick <= ~run_ev;
         end else begin
            presc     <= presc + PW'(1);
            step_tick <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_machdich_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_machdich_input_ctrl
//   Directed bench for machdich_input_ctrl with DEB_CYCLES=4, TICK_DIV=5,
//   AUTO_STEPS=3. Table-driven button vectors plus hand-written timing sequences.
//   The auto-cycle sequence runs when MACHDICH_AUTO_MODE_EN is defined. Without
//   it, the bench checks that the mode stays put while running.
// -----------------------------------------------------------------------------
module tb_machdich_input_ctrl;

   localparam int DEB    = 4;
   localparam int TDIV   = 5;
   localparam int ASTEPS = 3;

   logic       clk;
   logic       reset_n;
   logic       btn_run;
   logic       btn_mode;
   logic       ss;
   logic [1:0] mode;
   logic       step_tick;
   logic       mode_chg;

   int n_checks = 0;
   int n_err    = 0;
   int n_ticks  = 0;
   int n_chg    = 0;
   int n_viol   = 0;

   machdich_input_ctrl #(
      .DEB_CYCLES(DEB),
      .TICK_DIV  (TDIV),
      .AUTO_STEPS(ASTEPS)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_run  (btn_run),
      .btn_mode (btn_mode),
      .ss       (ss),
      .mode     (mode),
      .step_tick(step_tick),
      .mode_chg (mode_chg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       run;
      logic       md;
      int         width;
      logic       exp_ss;
      logic [1:0] exp_mode;
      int         exp_chg;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // One clock cycle; outputs are sampled on the falling edge.
   task automatic cyc1();
      @(negedge clk);
      if (step_tick) n_ticks++;
      if (mode_chg) n_chg++;
      if (step_tick && (ss || mode_chg)) n_viol++;
   endtask

   task automatic wait_n(input int n);
      repeat (n) cyc1();
   endtask

   // Hold the buttons for width cycles, release, and let the release settle.
   task automatic press(input logic run, input logic md, input int width);
      btn_run  = run;
      btn_mode = md;
      wait_n(width);
      btn_run  = 1'b0;
      btn_mode = 1'b0;
      wait_n(14);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: no finish by time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int   fall_at, rise_at, late, t0, c0, m_at, t_at, tog, found;
      int   tq[$];
      logic prev_ss;
      int   last_tick, hold_ticks, c1_t, c1_gap, c2_t;
      logic [1:0] c1_m, c2_m;

      vecs[0] = '{1'b1, 1'b0, 1, 1'b1, 2'd0, 0};
      vecs[1] = '{1'b1, 1'b0, 3, 1'b1, 2'd0, 0};
      vecs[2] = '{1'b0, 1'b1, 1, 1'b1, 2'd0, 0};
      vecs[3] = '{1'b0, 1'b1, 2, 1'b1, 2'd0, 0};
      vecs[4] = '{1'b0, 1'b1, 3, 1'b1, 2'd0, 0};
      vecs[5] = '{1'b0, 1'b1, 8, 1'b1, 2'd1, 1};
      vecs[6] = '{1'b0, 1'b1, 8, 1'b1, 2'd2, 1};
      vecs[7] = '{1'b0, 1'b1, 8, 1'b1, 2'd3, 1};
      vecs[8] = '{1'b0, 1'b1, 8, 1'b1, 2'd0, 1};

      // ---- reset state and idle ----
      reset_n  = 1'b0;
      btn_run  = 1'b0;
      btn_mode = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ss", ss, 1);
      check("rst_mode", mode, 0);
      check("rst_tick", step_tick, 0);
      check("rst_chg", mode_chg, 0);
      reset_n = 1'b1;
      wait_n(50);
      check("idle_ticks", n_ticks, 0);
      check("idle_chg", n_chg, 0);
      check("idle_ss", ss, 1);
      check("idle_mode", mode, 0);

      // ---- run start latency and tick pacing ----
      fall_at = -1;
      btn_run = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         cyc1();
         if (i == 20) btn_run = 1'b0;
         if (fall_at < 0 && ss == 1'b0) fall_at = i;
         if (step_tick) tq.push_back(i);
      end
      check("run_latency", fall_at, 7);
      check("first_tick", (tq.size() > 0) ? tq[0] : -1, 12);
      check("tick_count", tq.size(), 6);
      for (int k = 1; k < tq.size(); k++) check("tick_period", tq[k] - tq[k-1], TDIV);

      // ---- stop: the tick that would coincide with the toggle is dropped ----
      rise_at = -1;
      late    = 0;
      btn_run = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         cyc1();
         if (i == 10) btn_run = 1'b0;
         if (rise_at < 0 && ss == 1'b1) rise_at = i;
         if (i >= 7 && step_tick) late++;
      end
      check("stop_latency", rise_at, 7);
      check("no_tick_at_stop", late, 0);
      t0 = n_ticks;
      wait_n(30);
      check("hold_ticks", n_ticks - t0, 0);

      // ---- table: glitches rejected, clean presses step the mode ----
      for (int v = 0; v < 9; v++) begin
         c0 = n_chg;
         press(vecs[v].run, vecs[v].md, vecs[v].width);
         check($sformatf("vec%0d_ss", v), ss, vecs[v].exp_ss);
         check($sformatf("vec%0d_mode", v), mode, vecs[v].exp_mode);
         check($sformatf("vec%0d_chg", v), n_chg - c0, vecs[v].exp_chg);
      end

      // ---- mode change while running restarts the tick period ----
      press(1'b1, 1'b0, 8);
      check("run_started", ss, 0);
      m_at = -1;
      t_at = -1;
      btn_mode = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         cyc1();
         if (i == 8) btn_mode = 1'b0;
         if (m_at < 0 && mode_chg) m_at = i;
         else if (m_at >= 0 && t_at < 0 && step_tick) t_at = i;
      end
      check("mode_chg_latency", m_at, 7);
      check("tick_after_chg", t_at - m_at, TDIV);
      check("mode_running", mode, 1);
      press(1'b1, 1'b0, 8);
      check("stopped_again", ss, 1);

      // ---- bouncy press and bouncy release give one toggle ----
      tog     = 0;
      prev_ss = ss;
      for (int i = 0; i < 40; i++) begin
         btn_run = (i < 4) ? (i % 2 == 0) : (i < 16) ? 1'b1 : (i < 20) ? (i % 2 == 1) : 1'b0;
         cyc1();
         if (ss !== prev_ss) tog++;
         prev_ss = ss;
         if (i == 15) check("bounce_press_toggles", tog, 1);
      end
      check("bounce_total_toggles", tog, 1);
      check("bounce_ss", ss, 0);
      press(1'b1, 1'b0, 8);
      press(1'b0, 1'b1, 8);
      press(1'b0, 1'b1, 8);
      check("pre5_ss", ss, 1);
      check("pre5_mode", mode, 3);

      // ---- simultaneous RUN and MODE ----
      found    = -1;
      btn_run  = 1'b1;
      btn_mode = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         cyc1();
         if (i == 10) begin
            btn_run  = 1'b0;
            btn_mode = 1'b0;
         end
         if (found < 0 && ss == 1'b0) begin
            found = i;
            check("both_mode", mode, 0);
            check("both_chg", mode_chg, 1);
         end
      end
      check("both_latency", found, 7);
      wait_n(10);
      press(1'b0, 1'b1, 8);
      check("pre_rst_mode", mode, 1);
      check("pre_rst_ss", ss, 0);

      // ---- asynchronous reset mid tick period ----
      for (int i = 0; i < 8 && !step_tick; i++) cyc1();
      wait_n(2);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_ss", ss, 1);
      check("async_rst_mode", mode, 0);
      check("async_rst_tick", step_tick, 0);
      check("async_rst_chg", mode_chg, 0);
      @(negedge clk);
      reset_n = 1'b1;
      t0 = n_ticks;
      wait_n(20);
      check("post_rst_ss", ss, 1);
      check("post_rst_ticks", n_ticks - t0, 0);

      // ---- auto mode cycling (or its absence) ----
`ifdef MACHDICH_AUTO_MODE_EN
      t0         = n_ticks;
      last_tick  = -100;
      hold_ticks = -1;
      c1_t       = -1;
      c1_gap     = -1;
      c2_t       = -1;
      c1_m       = 2'd0;
      c2_m       = 2'd0;
      prev_ss    = ss;
      for (int i = 0; i < 100; i++) begin
         btn_run = (i < 4) || (i >= 8 && i < 12) || (i >= 55 && i < 59);
         cyc1();
         if (ss && !prev_ss && hold_ticks < 0) hold_ticks = n_ticks - t0;
         prev_ss = ss;
         if (mode_chg) begin
            if (c1_t < 0) begin
               c1_t   = n_ticks - t0;
               c1_m   = mode;
               c1_gap = (i + 1) - last_tick;
            end else if (c2_t < 0) begin
               c2_t = n_ticks - t0;
               c2_m = mode;
            end
         end
         if (step_tick) last_tick = i + 1;
      end
      check("auto_ticks_before_hold", hold_ticks, 1);
      check("auto_first_at_tick", c1_t, ASTEPS);
      check("auto_first_mode", c1_m, 1);
      check("auto_first_gap", c1_gap, 1);
      check("auto_second_at_tick", c2_t, 2 * ASTEPS);
      check("auto_second_mode", c2_m, 2);
      check("auto_running", ss, 0);
`else
      t0 = n_ticks;
      c0 = n_chg;
      for (int i = 0; i < 60; i++) begin
         btn_run = (i < 4);
         cyc1();
      end
      check("noauto_ticks", n_ticks - t0, 10);
      check("noauto_chg", n_chg - c0, 0);
      check("noauto_mode", mode, 0);
`endif
      press(1'b1, 1'b0, 8);
      check("final_hold", ss, 1);

      check("tick_with_hold_or_chg", n_viol, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
